dsm_ctrl: RTL and testbench
===========================

Name: dsm_ctrl

Overview:
Sequencing controller in front of DSM_top. Accepts low-rate signed PCM samples over a valid/ready handshake and buffers them in a small FIFO. Releases one sample per OSR clocks as a zero-order-held vin stream, and generates the LFSR dither word for dith_i. Owns the modulator's power-up/power-down sequence: prefill, slew-limited ramp from 0, run, slew-limited drain to 0, then holds DSM_top in reset.

Parameters:
W, 11, sample/vin/dither width (two's complement)
OSR, 64, clocks per input sample (>=2)
DEPTH, 4, FIFO entries (power of 2)
PREFILL, 2, FIFO level required before ramp starts (1..DEPTH)
STEP, 8, max |delta vin_o| per clock in RAMP/DRAIN
DITH_BITS, 3, LSBs of dither magnitude (1..W-1)
LFSR_SEED, 16'hACE1, nonzero reset value of 16-bit LFSR

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = run modulator, 0 = shut down
dith_en  in  1  1 = drive dither, 0 = dith_o forced 0
s_valid  in  1  input sample valid
s_data  in  W  input sample, signed
s_ready  out  1  FIFO can accept
vin_o  out  W  to DSM_top vin, signed
dith_o  out  W  to DSM_top dith_i, signed
dsm_rst  out  1  to DSM_top reset, active-high
underrun  out  1  one-clock pulse: sample tick with FIFO empty
fifo_level  out  clog2(DEPTH)+1  current occupancy
state_o  out  3  current state encoding

Behaviour:
- Reset (reset=0 at posedge): state IDLE, FIFO empty, hold=0, vin_o=0, dith_o=0, dsm_rst=1, underrun=0, tick counter=0, LFSR=LFSR_SEED. s_ready=1 (combinational; reflects IDLE, FIFO empty).
- Handshake: push when s_valid&&s_ready. s_ready = !full && state!=DRAIN. Data is registered; level updates next clock. Push and pop in the same cycle when full: pop frees the slot, but s_ready is still low that cycle, so no push. Same-cycle push and pop when not full: level unchanged.
- States: IDLE=0, PREFILL=1, RAMP=2, RUN=3, DRAIN=4. Transitions evaluated each clock.
- IDLE: dsm_rst=1, vin_o=0. Pushes accepted. enable=1 -> PREFILL.
- PREFILL: dsm_rst=1. If enable=0 -> IDLE, FIFO kept. If level>=PREFILL -> RAMP; on that edge: pop head into hold, tick counter cleared, dsm_rst=0.
- RAMP: dsm_rst=0. vin_o slews toward hold. enable=0 -> DRAIN (priority). vin_o==hold after update -> RUN.
- RUN: dsm_rst=0. vin_o=hold, same clock hold updates (1-cycle latency from pop). enable=0 -> DRAIN.
- DRAIN: dsm_rst=0. Target 0, vin_o slews to 0, no pops. When vin_o==0 -> IDLE; on that edge FIFO flushed, dsm_rst=1.
- Slew: d = target - vin_o in W+1 bits. vin_o += d if |d|<=STEP, else +/-STEP. No wrap possible.
- Sample tick: in RAMP/RUN the counter runs 0..OSR-1 and wraps. Tick occurs at count==OSR-1.
  - On tick, FIFO non-empty: pop into hold.
  - On tick, FIFO empty: hold retained, underrun pulses 1 clock.
  - Counter frozen at 0 in other states.
- Dither: 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every clock while dsm_rst=0.
  - dith_o = sign-extended signed value of LFSR[DITH_BITS:0] when dith_en, else 0. Registered, 1-cycle latency.
- Reset mid-operation: immediate return to reset values; FIFO contents discarded.
- enable toggling 1->0->1 during DRAIN: drain completes to IDLE first, then re-enters PREFILL.

Decomposition:
- Package dsm_pkg: state enum (IDLE..DRAIN), W default, LFSR_SEED, tap mask constant.
- One sub-module: dsm_sample_fifo (synchronous FIFO, push/pop/flush/level/full/empty, DEPTH param).
- LFSR, slew limiter and FSM stay inline in dsm_ctrl.

Test Plan:
1. Reset held 3 clocks with s_valid=1 -> dsm_rst=1, vin_o=0, dith_o=0, fifo_level=0, LFSR=16'hACE1 after release.
2. Push 100,200; enable=1 -> PREFILL->RAMP. vin_o=8,16,...,96,100 (13 clocks), state RUN. vin_o steps to 200 at tick 64 clocks after RAMP entry.
3. RUN, FIFO empty at tick -> underrun one-clock pulse, vin_o holds last value. Next push of -50 appears at following tick.
4. RUN with vin_o=-1000, enable=0 -> DRAIN, s_ready=0, vin_o=-992..-8,0 over 125 clocks. Then IDLE, dsm_rst=1, fifo_level=0.
5. Fill FIFO to 4 (s_ready=0). Push+pop same cycle at tick -> level 3, no data lost, order preserved.
6. dith_en=1, DITH_BITS=3 -> dith_o within [-8,7], matches reference LFSR model. dith_en=0 -> 0 next clock.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared types and constants for the delta-sigma modulator sequencing controller.
package dsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_RAMP    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4
  } dsm_state_e;

  localparam int          DSM_W         = 11;
  localparam logic [15:0] DSM_LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] DSM_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & DSM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Small synchronous sample FIFO with flush; level, full and empty come from a registered count.
module dsm_sample_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_s, do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == {LW{1'b0}});
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state pointers, storage and occupancy.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d = level_q + LW'(do_push_s) - LW'(do_pop_s);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/dsm_ctrl.sv
// Sequencer in front of DSM_top: buffers PCM samples, zero-order-holds them at the OSR rate,
// generates LFSR dither and runs the prefill / ramp / run / drain power sequence.
module dsm_ctrl
  import dsm_pkg::*;
#(
  parameter int          W         = DSM_W,
  parameter int          OSR       = 64,
  parameter int          DEPTH     = 4,
  parameter int          PREFILL   = 2,
  parameter int          STEP      = 8,
  parameter int          DITH_BITS = 3,
  parameter logic [15:0] LFSR_SEED = DSM_LFSR_SEED
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dith_en,
  input  logic                   s_valid,
  input  logic [W-1:0]           s_data,
  output logic                   s_ready,
  output logic [W-1:0]           vin_o,
  output logic [W-1:0]           dith_o,
  output logic                   dsm_rst,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [2:0]             state_o
);
  localparam int                LW       = $clog2(DEPTH) + 1;
  localparam int                CW       = $clog2(OSR);
  localparam logic [CW-1:0]     CNT_LAST = CW'(OSR - 1);
  localparam logic signed [W:0] STEP_POS = (W + 1)'(STEP);
  localparam logic signed [W:0] STEP_NEG = -STEP_POS;

  dsm_state_e          state_q, state_d;
  logic signed [W-1:0] vin_q, vin_d;
  logic signed [W-1:0] hold_q, hold_d;
  logic signed [W-1:0] dith_q, dith_d;
  logic                dsm_rst_q, dsm_rst_d;
  logic                underrun_q, underrun_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;

  logic                fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [W-1:0]        fifo_rdata_s;
  logic [LW-1:0]       fifo_level_s;
  logic                active_s, active_next_s, tick_s;
  logic signed [W:0]   slew_tgt_s, slew_cur_s, slew_diff_s, slew_step_s;
  logic signed [W-1:0] slew_vin_s;
  logic signed [DITH_BITS:0] dith_raw_s;

  assign s_ready     = !fifo_full_s && (state_q != ST_DRAIN);
  assign fifo_push_s = s_valid && s_ready;

  dsm_sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (fifo_flush_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Slew limiter: one clamped step toward hold (RAMP) or toward zero (DRAIN); W+1 bits cannot wrap.
  always_comb begin
    if (state_q == ST_DRAIN) begin
      slew_tgt_s = {(W + 1){1'b0}};
    end else begin
      slew_tgt_s = (W + 1)'(hold_q);
    end
    slew_cur_s  = (W + 1)'(vin_q);
    slew_diff_s = slew_tgt_s - slew_cur_s;
    if (slew_diff_s > STEP_POS) begin
      slew_step_s = STEP_POS;
    end else if (slew_diff_s < STEP_NEG) begin
      slew_step_s = STEP_NEG;
    end else begin
      slew_step_s = slew_diff_s;
    end
    slew_vin_s = W'(slew_cur_s + slew_step_s);
  end

  // Sequencing FSM, sample tick, hold register and FIFO pop/flush control.
  always_comb begin
    state_d      = state_q;
    vin_d        = vin_q;
    hold_d       = hold_q;
    underrun_d   = 1'b0;
    fifo_pop_s   = 1'b0;
    fifo_flush_s = 1'b0;
    active_s     = (state_q == ST_RAMP) || (state_q == ST_RUN);
    tick_s       = active_s && (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        vin_d = {W{1'b0}};
        if (enable) begin
          state_d = ST_PREFILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREFILL: begin
        vin_d = {W{1'b0}};
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fifo_level_s >= LW'(PREFILL)) begin
          state_d    = ST_RAMP;
          fifo_pop_s = 1'b1;
          hold_d     = fifo_rdata_s;
        end else begin
          state_d = ST_PREFILL;
        end
      end
      ST_RAMP: begin
        vin_d = slew_vin_s;
        if (!enable) begin
          state_d = ST_DRAIN;
        end else if (slew_vin_s == hold_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RAMP;
        end
      end
      ST_RUN: begin
        vin_d = hold_q;
        if (!enable) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        vin_d = slew_vin_s;
        if (slew_vin_s == {W{1'b0}}) begin
          state_d      = ST_IDLE;
          fifo_flush_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vin_d   = {W{1'b0}};
      end
    endcase

    // A tick with nothing buffered keeps the previous sample and flags the gap.
    if (tick_s) begin
      if (!fifo_empty_s) begin
        fifo_pop_s = 1'b1;
        hold_d     = fifo_rdata_s;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    active_next_s = (state_d == ST_RAMP) || (state_d == ST_RUN);
    if (active_s && active_next_s) begin
      if (tick_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end

    dsm_rst_d = (state_d == ST_IDLE) || (state_d == ST_PREFILL);
  end

  // Dither LFSR runs only while the modulator is out of reset; output word is registered.
  always_comb begin
    if (dsm_rst_q) begin
      lfsr_d = lfsr_q;
    end else begin
      lfsr_d = lfsr_next(lfsr_q);
    end
    dith_raw_s = lfsr_q[DITH_BITS:0];
    if (dith_en) begin
      dith_d = W'(dith_raw_s);
    end else begin
      dith_d = {W{1'b0}};
    end
  end

  // Controller state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      vin_q      <= {W{1'b0}};
      hold_q     <= {W{1'b0}};
      dith_q     <= {W{1'b0}};
      dsm_rst_q  <= 1'b1;
      underrun_q <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      vin_q      <= vin_d;
      hold_q     <= hold_d;
      dith_q     <= dith_d;
      dsm_rst_q  <= dsm_rst_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign vin_o      = vin_q;
  assign dith_o     = dith_q;
  assign dsm_rst    = dsm_rst_q;
  assign underrun   = underrun_q;
  assign fifo_level = fifo_level_s;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dsm_ctrl.sv
// Scoreboard bench for dsm_ctrl: a queue/integer reference model predicts every cycle's outputs,
// a negedge monitor pops and compares; directed checkpoints cover the documented sequences.
module tb_dsm_ctrl;
  localparam int W         = 11;
  localparam int OSR       = 64;
  localparam int DEPTH     = 4;
  localparam int PREFILL   = 2;
  localparam int STEP      = 8;
  localparam int DITH_BITS = 3;

  logic         clock = 1'b0;
  logic         reset, enable, dith_en, s_valid;
  logic [W-1:0] s_data;
  logic         s_ready, dsm_rst, underrun;
  logic [W-1:0] vin_o, dith_o;
  logic [2:0]   fifo_level;
  logic [2:0]   state_o;

  dsm_ctrl #(
    .W(W), .OSR(OSR), .DEPTH(DEPTH), .PREFILL(PREFILL), .STEP(STEP),
    .DITH_BITS(DITH_BITS), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .dith_en(dith_en),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .vin_o(vin_o), .dith_o(dith_o), .dsm_rst(dsm_rst), .underrun(underrun),
    .fifo_level(fifo_level), .state_o(state_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int vin; int dith; int rst; int under; int level; int state; int ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: states by number, FIFO as a queue, counter = cycles since ramp entry mod OSR.
  int m_state, m_vin, m_hold, m_cnt, m_under, m_dith, m_rst, m_lfsr;
  int m_fifo[$];

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slew_to(int cur, int tgt);
    if (tgt - cur > STEP) return cur + STEP;
    if (tgt - cur < -STEP) return cur - STEP;
    return tgt;
  endfunction

  function automatic int lfsr_adv(int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'h0000FFFF;
  endfunction

  function automatic int dith_of(int l);
    int v;
    v = l % (2 ** (DITH_BITS + 1));
    if (v >= 2 ** DITH_BITS) v -= 2 ** (DITH_BITS + 1);
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_vin = 0; m_hold = 0; m_cnt = 0; m_under = 0;
    m_dith = 0; m_rst = 1; m_lfsr = 32'h0000ACE1;
    m_fifo.delete();
  endtask

  task automatic model_step(bit rstn, bit en, bit den, bit valid, int d);
    bit ready, tick, running, running_next;
    int n_state, n_vin, n_hold, n_under;
    if (!rstn) begin
      model_reset();
      return;
    end
    ready   = (m_fifo.size() < DEPTH) && (m_state != 4);
    running = (m_state == 2) || (m_state == 3);
    tick    = running && (m_cnt == OSR - 1);
    n_state = m_state; n_vin = m_vin; n_hold = m_hold; n_under = 0;
    case (m_state)
      0: begin n_vin = 0; if (en) n_state = 1; end
      1: begin
        n_vin = 0;
        if (!en) n_state = 0;
        else if (m_fifo.size() >= PREFILL) begin n_state = 2; n_hold = m_fifo.pop_front(); end
      end
      2: begin
        n_vin = slew_to(m_vin, m_hold);
        if (!en) n_state = 4; else if (n_vin == m_hold) n_state = 3;
      end
      3: begin n_vin = m_hold; if (!en) n_state = 4; end
      default: begin n_vin = slew_to(m_vin, 0); if (n_vin == 0) n_state = 0; end
    endcase
    if (tick) begin
      if (m_fifo.size() > 0) n_hold = m_fifo.pop_front();
      else n_under = 1;
    end
    if (valid && ready) m_fifo.push_back(d);
    if (m_state == 4 && n_state == 0) m_fifo.delete();
    running_next = (n_state == 2) || (n_state == 3);
    if (running && running_next) m_cnt = (m_cnt + 1) % OSR;
    else m_cnt = 0;
    m_dith = den ? dith_of(m_lfsr) : 0;
    if (!m_rst) m_lfsr = lfsr_adv(m_lfsr);
    m_rst   = (n_state <= 1) ? 1 : 0;
    m_state = n_state; m_vin = n_vin; m_hold = n_hold; m_under = n_under;
  endtask

  // One clock: drive inputs, queue this cycle's expected outputs, advance model, step past the edge.
  task automatic cyc(bit rstn, bit en, bit den, bit valid, int d);
    exp_t e;
    reset = rstn; enable = en; dith_en = den; s_valid = valid; s_data = d[W-1:0];
    e.vin = m_vin; e.dith = m_dith; e.rst = m_rst; e.under = m_under;
    e.level = m_fifo.size(); e.state = m_state;
    e.ready = ((m_fifo.size() < DEPTH) && (m_state != 4)) ? 1 : 0;
    exp_q.push_back(e);
    model_step(rstn, en, den, valid, d);
    @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it with the oldest prediction.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("vin_o",      int'($signed(vin_o)),  mon_e.vin);
      check("dith_o",     int'($signed(dith_o)), mon_e.dith);
      check("dsm_rst",    int'(dsm_rst),         mon_e.rst);
      check("underrun",   int'(underrun),        mon_e.under);
      check("fifo_level", int'(fifo_level),      mon_e.level);
      check("state_o",    int'(state_o),         mon_e.state);
      check("s_ready",    int'(s_ready),         mon_e.ready);
    end
  end

  int vals[4] = '{300, -300, 500, -500};

  initial begin
    bit en, den, rs, v;
    int d;
    reset = 1'b0; enable = 1'b0; dith_en = 1'b1; s_valid = 1'b1; s_data = '0;
    model_reset();
    @(posedge clock);
    #1;

    // Reset held with s_valid asserted: nothing may be accepted.
    repeat (3) cyc(0, 0, 1, 1, 0);
    check("rst_dsm_rst", int'(dsm_rst), 1);
    check("rst_vin", int'($signed(vin_o)), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(s_ready), 1);

    // Prefill two samples, then ramp 0 -> 100 in 13 clocks of STEP 8.
    cyc(1, 0, 1, 1, 100);
    check("seed_dither", int'($signed(dith_o)), 1);
    cyc(1, 0, 1, 1, 200);
    check("prefill_level", int'(fifo_level), 2);
    repeat (15) cyc(1, 1, 1, 0, 0);
    check("ramp_end_vin", int'($signed(vin_o)), 100);
    check("ramp_end_state", int'(state_o), 3);
    repeat (51) cyc(1, 1, 1, 0, 0);
    check("pre_tick_vin", int'($signed(vin_o)), 100);
    cyc(1, 1, 1, 0, 0);
    check("tick_vin", int'($signed(vin_o)), 200);

    // Empty FIFO at the next tick: one-clock underrun, value held.
    repeat (63) cyc(1, 1, 1, 0, 0);
    check("underrun_pulse", int'(underrun), 1);
    cyc(1, 1, 1, 0, 0);
    check("underrun_clear", int'(underrun), 0);
    check("underrun_hold", int'($signed(vin_o)), 200);
    cyc(1, 1, 1, 1, -50);
    cyc(1, 1, 1, 1, -1000);
    repeat (126) cyc(1, 1, 1, 0, 0);
    check("run_vin_m1000", int'($signed(vin_o)), -1000);

    // Drain from -1000 to 0 in 125 clocks, then back to IDLE with the modulator held in reset.
    cyc(1, 0, 1, 0, 0);
    check("drain_state", int'(state_o), 4);
    check("drain_ready", int'(s_ready), 0);
    repeat (124) cyc(1, 0, 1, 0, 0);
    check("drain_last_vin", int'($signed(vin_o)), -8);
    cyc(1, 0, 1, 0, 0);
    check("drain_done_vin", int'($signed(vin_o)), 0);
    check("drain_done_state", int'(state_o), 0);
    check("drain_done_rst", int'(dsm_rst), 1);

    // Fill to DEPTH, then push+pop contention at ticks with s_valid held high.
    for (int k = 0; k < 4; k++) cyc(1, 0, 1, 1, vals[k]);
    check("full_level", int'(fifo_level), 4);
    check("full_ready", int'(s_ready), 0);
    cyc(1, 0, 1, 1, 777);
    check("full_no_push", int'(fifo_level), 4);
    repeat (2) cyc(1, 1, 1, 1, 777);
    check("full_pop_level", int'(fifo_level), 3);
    for (int k = 0; k < 200; k++) cyc(1, 1, 1, 1, int'($urandom_range(0, 2047)) - 1024);
    repeat (300) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("dither_off", int'($signed(dith_o)), 0);

    // Randomised traffic, enable/dither toggling and occasional mid-run reset.
    en = 1'b1; den = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) en = !en;
      if ($urandom_range(0, 49) == 0) den = !den;
      rs = ($urandom_range(0, 1499) != 0);
      v  = ($urandom_range(0, (i < 1500) ? 39 : 89) == 0);
      d  = int'($urandom_range(0, 2047)) - 1024;
      cyc(rs, en, den, v, d);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
